upsampler_variable: RTL and testbench

- Variable-rate interpolating front-end: the transmit-side counterpart of the variable-rate decimating downsampler; feeds the CIC interpolator integrator chain.
- Each accepted input sample expands into R output samples, where R is run-time programmable.
- Phase 0 of each burst carries the sample. Phases 1..R-1 carry either zeros (zero-stuffing) or the held sample, selected by parameter.
- AXI-Stream style valid/ready on data in and data out; the rate port is valid-only.

---
 rtl/upsampler_variable.sv | 68 ++++++
 tb/tb_upsampler_variable.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/upsampler_variable.sv
// upsampler_variable: variable-rate interpolating front-end that expands each accepted sample into R output phases
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-high reset
//   s_axis_in_tdata/tvalid/tready   input sample stream (signed)
//   s_axis_rate_tdata/tvalid        interpolation factor R load (valid-only; R = 0 is stored as 1)
//   m_axis_out_tdata/tvalid/tready  output sample stream (signed)
module upsampler_variable #(
  parameter int DATA_WIDTH_INP  = 8,
  parameter int DATA_WIDTH_RATE = 16,
  parameter int HOLD_MODE       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH_INP-1:0]  s_axis_in_tdata,
  input  logic                       s_axis_in_tvalid,
  output logic                       s_axis_in_tready,
  input  logic [DATA_WIDTH_RATE-1:0] s_axis_rate_tdata,
  input  logic                       s_axis_rate_tvalid,
  output logic [DATA_WIDTH_INP-1:0]  m_axis_out_tdata,
  output logic                       m_axis_out_tvalid,
  input  logic                       m_axis_out_tready
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t                     state;
  logic [DATA_WIDTH_RATE-1:0] rate_buf, phase, rate_m1;
  logic [DATA_WIDTH_INP-1:0]  held;
  logic                       last_phase, in_hs, out_hs;
  // rate_buf is never 0, so rate_m1 cannot wrap; compare stays at rate width
  assign rate_m1    = rate_buf - 1'b1;
  assign last_phase = phase == rate_m1;
  // Combinational path from out_tready lets the next sample load on the last phase with no bubble
  assign s_axis_in_tready = !reset && !s_axis_rate_tvalid &&
                            (state == IDLE || (last_phase && m_axis_out_tready));
  assign in_hs  = s_axis_in_tvalid && s_axis_in_tready;
  assign out_hs = m_axis_out_tvalid && m_axis_out_tready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_buf          <= DATA_WIDTH_RATE'(1);
      phase             <= '0;
      state             <= IDLE;
      held              <= '0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tvalid <= 1'b0;
    end else if (s_axis_rate_tvalid) begin
      // a rate load discards any partial burst
      rate_buf          <= (s_axis_rate_tdata == '0) ? DATA_WIDTH_RATE'(1) : s_axis_rate_tdata;
      phase             <= '0;
      state             <= IDLE;
      m_axis_out_tdata  <= '0;
      m_axis_out_tvalid <= 1'b0;
    end else if (in_hs) begin
      held              <= s_axis_in_tdata;
      m_axis_out_tdata  <= s_axis_in_tdata;
      m_axis_out_tvalid <= 1'b1;
      phase             <= '0;
      state             <= BURST;
    end else if (state == BURST && out_hs) begin
      if (last_phase) begin
        m_axis_out_tdata  <= '0;
        m_axis_out_tvalid <= 1'b0;
        state             <= IDLE;
      end else begin
        phase             <= phase + 1'b1;
        m_axis_out_tdata  <= (HOLD_MODE != 0) ? held : '0;
      end
    end
  end
endmodule

// File: tb/tb_upsampler_variable.sv
// tb_upsampler_variable: table-driven check of zero-stuff and hold variants plus reset and max-rate sequences
module tb_upsampler_variable;
  logic        clk, reset;
  logic        iv, rv, ordy;
  logic [7:0]  id;
  logic [15:0] rd;
  logic        rdy0, rdy1, rdy2, v0, v1, v2;
  logic [7:0]  d0, d1, d2;
  int          checks = 0, errors = 0;

  upsampler_variable #(.DATA_WIDTH_INP(8), .DATA_WIDTH_RATE(16), .HOLD_MODE(0)) dut0 (
    .clk(clk), .reset(reset),
    .s_axis_in_tdata(id), .s_axis_in_tvalid(iv), .s_axis_in_tready(rdy0),
    .s_axis_rate_tdata(rd), .s_axis_rate_tvalid(rv),
    .m_axis_out_tdata(d0), .m_axis_out_tvalid(v0), .m_axis_out_tready(ordy));
  upsampler_variable #(.DATA_WIDTH_INP(8), .DATA_WIDTH_RATE(16), .HOLD_MODE(1)) dut1 (
    .clk(clk), .reset(reset),
    .s_axis_in_tdata(id), .s_axis_in_tvalid(iv), .s_axis_in_tready(rdy1),
    .s_axis_rate_tdata(rd), .s_axis_rate_tvalid(rv),
    .m_axis_out_tdata(d1), .m_axis_out_tvalid(v1), .m_axis_out_tready(ordy));
  upsampler_variable #(.DATA_WIDTH_INP(8), .DATA_WIDTH_RATE(4), .HOLD_MODE(0)) dut2 (
    .clk(clk), .reset(reset),
    .s_axis_in_tdata(id), .s_axis_in_tvalid(iv), .s_axis_in_tready(rdy2),
    .s_axis_rate_tdata(rd[3:0]), .s_axis_rate_tvalid(rv),
    .m_axis_out_tdata(d2), .m_axis_out_tvalid(v2), .m_axis_out_tready(ordy));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       rv;
    logic [15:0] rd;
    logic       ordy;
    logic       e_rdy;
    logic       e_v;
    logic [7:0] e_d0;
    logic [7:0] e_d1;
  } vec_t;
  vec_t q[$];

  function automatic void add(input logic a_iv, input int a_id, input logic a_rv, input int a_rd,
                              input logic a_ordy, input logic a_rdy, input logic a_v,
                              input int a_d0, input int a_d1);
    vec_t t;
    t.iv = a_iv; t.id = 8'(a_id); t.rv = a_rv; t.rd = 16'(a_rd); t.ordy = a_ordy;
    t.e_rdy = a_rdy; t.e_v = a_v; t.e_d0 = 8'(a_d0); t.e_d1 = 8'(a_d1);
    q.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    reset = 1; iv = 0; id = 0; rv = 0; rd = 0; ordy = 1;
    #2;
    chk("rst_v0", 32'(v0), 0);
    chk("rst_d0", 32'(d0), 0);
    chk("rst_rdy0", 32'(rdy0), 0);
    chk("rst_v1", 32'(v1), 0);
    @(posedge clk); #1;
    reset = 0;
    // R=4 zero-stuff vs hold, back-to-back 5, -3
    add(1, 5, 1, 4, 1, 0, 0, 0, 0);
    add(1, 5, 0, 0, 1, 1, 1, 5, 5);
    add(1, -3, 0, 0, 1, 0, 1, 0, 5);
    add(1, -3, 0, 0, 1, 0, 1, 0, 5);
    add(1, -3, 0, 0, 1, 0, 1, 0, 5);
    add(1, -3, 0, 0, 1, 1, 1, -3, -3);
    add(0, 0, 0, 0, 1, 0, 1, 0, -3);
    add(0, 0, 0, 0, 1, 0, 1, 0, -3);
    add(0, 0, 0, 0, 1, 0, 1, 0, -3);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    // R=3, 7 then -8, out_tready toggled 1,0,0,1
    add(0, 0, 1, 3, 1, 0, 0, 0, 0);
    add(1, 7, 0, 0, 1, 1, 1, 7, 7);
    add(1, -8, 0, 0, 1, 0, 1, 0, 7);
    add(1, -8, 0, 0, 0, 0, 1, 0, 7);
    add(1, -8, 0, 0, 0, 0, 1, 0, 7);
    add(1, -8, 0, 0, 1, 0, 1, 0, 7);
    add(1, -8, 0, 0, 1, 1, 1, -8, -8);
    add(0, 0, 0, 0, 1, 0, 1, 0, -8);
    add(0, 0, 0, 0, 1, 0, 1, 0, -8);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    // rate load 0 acts as R=1 register slice
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1, 1, 1, 1);
    add(1, 2, 0, 0, 1, 1, 1, 2, 2);
    add(1, 3, 0, 0, 0, 0, 1, 2, 2);
    add(1, 3, 0, 0, 1, 1, 1, 3, 3);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    // R=5 burst aborted by rate load 2 during phase 1
    add(0, 0, 1, 5, 1, 0, 0, 0, 0);
    add(1, 11, 0, 0, 1, 1, 1, 11, 11);
    add(0, 0, 0, 0, 1, 0, 1, 0, 11);
    add(1, 9, 1, 2, 1, 0, 0, 0, 0);
    add(1, 9, 0, 0, 1, 1, 1, 9, 9);
    add(0, 0, 0, 0, 1, 0, 1, 0, 9);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    // R=2, out_tready low for 10 cycles, then a stall on the last phase
    add(1, 6, 0, 0, 0, 1, 1, 6, 6);
    for (int k = 0; k < 10; k++) add(1, 13, 0, 0, 0, 0, 1, 6, 6);
    add(1, 13, 0, 0, 1, 0, 1, 0, 6);
    add(1, 13, 0, 0, 0, 0, 1, 0, 6);
    add(1, 13, 0, 0, 1, 1, 1, 13, 13);
    add(0, 0, 0, 0, 1, 0, 1, 0, 13);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    foreach (q[i]) begin
      iv = q[i].iv; id = q[i].id; rv = q[i].rv; rd = q[i].rd; ordy = q[i].ordy;
      #1;
      chk($sformatf("vec%0d in_tready0", i), 32'(rdy0), 32'(q[i].e_rdy));
      chk($sformatf("vec%0d in_tready1", i), 32'(rdy1), 32'(q[i].e_rdy));
      chk($sformatf("vec%0d in_tready2", i), 32'(rdy2), 32'(q[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_tvalid0", i), 32'(v0), 32'(q[i].e_v));
      chk($sformatf("vec%0d out_tdata0", i), 32'(d0), 32'(q[i].e_d0));
      chk($sformatf("vec%0d out_tvalid1", i), 32'(v1), 32'(q[i].e_v));
      chk($sformatf("vec%0d out_tdata1", i), 32'(d1), 32'(q[i].e_d1));
      chk($sformatf("vec%0d out_tvalid2", i), 32'(v2), 32'(q[i].e_v));
      chk($sformatf("vec%0d out_tdata2", i), 32'(d2), 32'(q[i].e_d0));
    end
    // asynchronous reset mid-burst (R=2 still loaded)
    iv = 1; id = 21; rv = 0; ordy = 1;
    @(posedge clk); #1;
    chk("arst_pre_v0", 32'(v0), 1);
    chk("arst_pre_d0", 32'(d0), 21);
    iv = 0;
    #3;
    reset = 1;
    #1;
    chk("arst_v0", 32'(v0), 0);
    chk("arst_d0", 32'(d0), 0);
    chk("arst_rdy0", 32'(rdy0), 0);
    chk("arst_v1", 32'(v1), 0);
    @(posedge clk); #3;
    reset = 0;
    iv = 1; id = 4;
    #1;
    chk("post_rdy0", 32'(rdy0), 1);
    @(posedge clk); #1;
    chk("post_v0", 32'(v0), 1);
    chk("post_d0", 32'(d0), 4);
    iv = 0;
    #1;
    chk("post_rdy_last", 32'(rdy0), 1);
    @(posedge clk); #1;
    chk("post_single_v0", 32'(v0), 0);
    chk("post_single_v1", 32'(v1), 0);
    // maximum rate on a 4-bit rate word: 15 phases, no wrap
    rv = 1; rd = 15;
    @(posedge clk); #1;
    rv = 0; iv = 1; id = 3;
    #1;
    chk("max_rdy2", 32'(rdy2), 1);
    @(posedge clk); #1;
    iv = 0;
    chk("max_first_d2", 32'(d2), 3);
    n = 0;
    while (v2 === 1'b1 && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("max_burst_len", 32'(n), 15);
    chk("max_idle_rdy2", 32'(rdy2), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
